// File: rtl/equiv_checker.sv
// Exhaustive equivalence sweep: walks every input vector, compares original vs simplified outputs,
// counts failing vectors and latches the first one. Optional: EQUIV_STOP_ON_FAIL_EN stops on first mismatch.
//
// state | meaning
// IDLE  | waiting for start, results cleared by reset
// RUN   | driving vec, sampling stage 1, accumulating stage 2
// DRAIN | accumulating the last sampled vector
// DONE  | results held until the next start
module equiv_checker #(
  parameter int N_IN  = 6,
  parameter int NPAIR = 3,
  parameter int CNT_W = 7  // must be >= N_IN+1 so a full-fail sweep fits
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   vec,
  input  logic [NPAIR-1:0]  ref_in,
  input  logic [NPAIR-1:0]  dut_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              fail_seen,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic [NPAIR-1:0]  first_fail_mask
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [N_IN-1:0]  VEC_LAST = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state;
  logic [NPAIR-1:0]  mm;
  logic [N_IN-1:0]   vec_d;
  logic              mm_vld;
  logic              mm_hit;
  logic              stop_now;
  logic [CNT_W-1:0]  err_cnt_inc;

  always_comb begin
    mm_hit      = mm_vld & (|mm);
    err_cnt_inc = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + 1'b1;
`ifdef EQUIV_STOP_ON_FAIL_EN
    stop_now    = mm_hit & ~fail_seen;
`else
    stop_now    = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      vec             <= '0;
      vec_d           <= '0;
      mm              <= '0;
      mm_vld          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      fail_seen       <= 1'b0;
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state           <= S_RUN;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            vec             <= '0;
            mm_vld          <= 1'b0;
            err_cnt         <= '0;
            fail_seen       <= 1'b0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
          end
        end
        S_RUN: begin
          if (stop_now) begin
            // vec is already first_fail_vec+1 (or all-ones); the in-flight sample is dropped
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            pass   <= 1'b0;
            mm_vld <= 1'b0;
          end else begin
            mm     <= ref_in ^ dut_in;
            vec_d  <= vec;
            mm_vld <= 1'b1;
            if (vec == VEC_LAST) state <= S_DRAIN;
            else                 vec   <= vec + 1'b1;
          end
        end
        S_DRAIN: begin
          state  <= S_DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
          mm_vld <= 1'b0;
          pass   <= ~mm_hit & (err_cnt == '0);
        end
        default: state <= S_IDLE;
      endcase

      if (mm_hit && (state == S_RUN || state == S_DRAIN)) begin
        err_cnt <= err_cnt_inc;
        if (!fail_seen) begin
          fail_seen       <= 1'b1;
          first_fail_vec  <= vec_d;
          first_fail_mask <= mm;
        end
      end
    end
  end

endmodule

// File: tb/tb_equiv_checker.sv
// Randomised bench for equiv_checker: random truth tables with injected fault tables,
// expectations from a vector-level model of the sweep.
module tb_equiv_checker;

  localparam int N_IN  = 6;
  localparam int NPAIR = 3;
  localparam int CNT_W = 7;
  localparam int NVEC  = 1 << N_IN;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [N_IN-1:0]   vec;
  logic [NPAIR-1:0]  ref_in;
  logic [NPAIR-1:0]  dut_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  err_cnt;
  logic              fail_seen;
  logic [N_IN-1:0]   first_fail_vec;
  logic [NPAIR-1:0]  first_fail_mask;

  logic [NPAIR-1:0]  tt  [NVEC];
  logic [NPAIR-1:0]  flt [NVEC];

  int n_assert = 0;
  int n_fail   = 0;

  int              exp_edges;
  int              exp_err;
  logic [N_IN-1:0] exp_first;
  logic [N_IN-1:0] exp_vec;
  logic [NPAIR-1:0] exp_mask;
  logic            exp_fs;

  always #5 clk = ~clk;

  assign ref_in = tt[vec];
  assign dut_in = tt[vec] ^ flt[vec];

  equiv_checker #(.N_IN(N_IN), .NPAIR(NPAIR), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .vec(vec),
    .ref_in(ref_in), .dut_in(dut_in),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_seen(fail_seen), .first_fail_vec(first_fail_vec), .first_fail_mask(first_fail_mask)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/vec"}, 32'(vec), 0);
    chk({tag, "/busy"}, 32'(busy), 0);
    chk({tag, "/done"}, 32'(done), 0);
    chk({tag, "/pass"}, 32'(pass), 0);
    chk({tag, "/err_cnt"}, 32'(err_cnt), 0);
    chk({tag, "/fail_seen"}, 32'(fail_seen), 0);
    chk({tag, "/ffv"}, 32'(first_fail_vec), 0);
    chk({tag, "/ffm"}, 32'(first_fail_mask), 0);
  endtask

  // What the sweep should report, derived directly from the fault table.
  task automatic model();
    int first = -1;
    int cnt = 0;
    for (int v = 0; v < NVEC; v++) begin
      if (flt[v] != '0) begin
        cnt++;
        if (first < 0) first = v;
      end
    end
    exp_fs    = (first >= 0);
    exp_first = exp_fs ? N_IN'(first) : '0;
    exp_mask  = exp_fs ? flt[first] : '0;
`ifdef EQUIV_STOP_ON_FAIL_EN
    if (exp_fs) begin
      exp_edges = first + 2;
      exp_err   = 1;
      exp_vec   = (first == NVEC - 1) ? N_IN'(NVEC - 1) : N_IN'(first + 1);
    end else begin
      exp_edges = NVEC + 1;
      exp_err   = 0;
      exp_vec   = N_IN'(NVEC - 1);
    end
`else
    exp_edges = NVEC + 1;
    exp_err   = cnt;
    exp_vec   = N_IN'(NVEC - 1);
`endif
  endtask

  task automatic randomize_tt();
    for (int v = 0; v < NVEC; v++) tt[v] = NPAIR'($urandom_range(0, (1 << NPAIR) - 1));
  endtask

  task automatic clear_flt();
    for (int v = 0; v < NVEC; v++) flt[v] = '0;
  endtask

  task automatic start_run(input string tag, input bit hold);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "/start_busy"}, 32'(busy), 1);
    chk({tag, "/start_done"}, 32'(done), 0);
    chk({tag, "/start_vec"}, 32'(vec), 0);
    chk({tag, "/start_err"}, 32'(err_cnt), 0);
    chk({tag, "/start_fs"}, 32'(fail_seen), 0);
    if (!hold) @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int got = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (busy && !done) chk({tag, "/vec_walk"}, 32'(vec), (n < NVEC - 1) ? n : NVEC - 1);
      if (done) begin
        got = n;
        break;
      end
    end
    chk({tag, "/done_edges"}, got, exp_edges);
  endtask

  task automatic check_results(input string tag);
    chk({tag, "/busy"}, 32'(busy), 0);
    chk({tag, "/done"}, 32'(done), 1);
    chk({tag, "/err_cnt"}, 32'(err_cnt), exp_err);
    chk({tag, "/pass"}, 32'(pass), (exp_err == 0) ? 1 : 0);
    chk({tag, "/fail_seen"}, 32'(fail_seen), 32'(exp_fs));
    chk({tag, "/ffv"}, 32'(first_fail_vec), 32'(exp_first));
    chk({tag, "/ffm"}, 32'(first_fail_mask), 32'(exp_mask));
    chk({tag, "/vec"}, 32'(vec), 32'(exp_vec));
  endtask

  task automatic do_run(input string tag);
    model();
    start_run(tag, 1'b0);
    wait_done(tag);
    check_results(tag);
  endtask

  initial begin
    randomize_tt();
    clear_flt();

    // reset
    #2;
    chk_all_zero("in_reset");
    #20 rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("after_reset");

    // equivalent functions
    do_run("equal");
    repeat (3) @(posedge clk);
    #1;
    check_results("equal_hold");

    // single fault at 0x2A, bit 0
    randomize_tt();
    clear_flt();
    flt[6'h2A] = 3'b001;
    do_run("one_fault");

    // fully inverted
    for (int v = 0; v < NVEC; v++) flt[v] = 3'b111;
    do_run("inverted");

    // faults at 5 and 0x30
    clear_flt();
    flt[6'h05] = 3'b010;
    flt[6'h30] = 3'b101;
    do_run("two_faults");

    // fault only on the last vector, accumulated in DRAIN
    clear_flt();
    flt[NVEC - 1] = 3'b100;
    do_run("last_vec");

    // fault only on the second-to-last vector
    clear_flt();
    flt[NVEC - 2] = 3'b011;
    do_run("penult_vec");

    // random fault tables
    for (int r = 0; r < 4; r++) begin
      randomize_tt();
      for (int v = 0; v < NVEC; v++)
        flt[v] = ($urandom_range(0, 5) == 0) ? NPAIR'($urandom_range(1, (1 << NPAIR) - 1)) : '0;
      do_run("random");
    end

    // reset mid-run at vec 0x14
    for (int v = 0; v < NVEC; v++) flt[v] = 3'b110;
    start_run("rst_mid", 1'b0);
    begin
      bit found = 1'b0;
      for (int n = 0; n < 100; n++) begin
        @(posedge clk);
        #1;
        if (vec == 6'h14) begin
          found = 1'b1;
          break;
        end
      end
      chk("rst_mid/reach_14", 32'(found), 1);
    end
    #2 rst = 1'b1;
    #1;
    chk_all_zero("rst_mid_async");
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("rst_mid_idle");
    clear_flt();
    do_run("after_rst");

    // start held high: ignored while busy, DONE re-enters RUN with clears
    for (int v = 0; v < NVEC; v++) flt[v] = 3'b111;
    model();
    start_run("held", 1'b1);
    wait_done("held1");
    check_results("held1");
    @(posedge clk);
    #1;
    chk("held/rerun_done", 32'(done), 0);
    chk("held/rerun_busy", 32'(busy), 1);
    chk("held/rerun_vec", 32'(vec), 0);
    chk("held/rerun_err", 32'(err_cnt), 0);
    chk("held/rerun_fs", 32'(fail_seen), 0);
    chk("held/rerun_ffm", 32'(first_fail_mask), 0);
    @(negedge clk) start = 1'b0;
    wait_done("held2");
    check_results("held2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
